// File: rtl/fetch_unit_32_pkg.sv
// Shared definitions for the fetch unit and the control decoder:
// jump-select encodings, reset vector and fetch FSM state codes.
package fetch_unit_32_pkg;

  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_J   = 2'b01;
  localparam logic [1:0] JUMP_JR  = 2'b10;
  localparam logic [1:0] JUMP_INV = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_32_next_pc.sv
// Combinational next-PC selection for the instruction held in the fetch unit,
// plus the fault condition (invalid select or misaligned target).
module next_pc_32
  import fetch_unit_32_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic [25:0] imm26,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        fault
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = instr_pc + 32'd4;

  // A nonzero jump select always wins over the branch flag.
  always_comb begin
    next_pc = pc_plus4;
    case (jump)
      JUMP_J:   next_pc = {pc_plus4[31:28], imm26, 2'b00};
      JUMP_JR:  next_pc = jr_target;
      JUMP_SEQ: if (branch && alu_zero) next_pc = pc_plus4 + branch_offset(imm26[15:0]);
      default:  next_pc = pc_plus4;
    endcase
  end

  assign fault = (jump == JUMP_INV) || (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit_32.sv
// Instruction fetch unit: requests one word at a time, holds it until the
// datapath retires it, then advances the PC; faults park the unit in HALT.
module fetch_unit_32
  import fetch_unit_32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [31:0] jr_target,
  output logic        err_fetch
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        next_fault;

  next_pc_32 u_next_pc (
    .instr_pc  (instr_pc),
    .imm26     (instr[25:0]),
    .jump      (jump),
    .branch    (branch),
    .alu_zero  (alu_zero),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .fault     (next_fault)
  );

  // Gating with rst_n keeps the request low during reset, dropping any
  // outstanding request immediately.
  assign imem_req    = rst_n && (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_HOLD);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      instr     <= '0;
      instr_pc  <= '0;
      err_fetch <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc;
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            if (next_fault) begin
              err_fetch <= 1'b1;
              state     <= ST_HALT;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit_32.sv
// Directed self-checking bench for fetch_unit_32 with hand-computed addresses.
module tb_fetch_unit_32;
  import fetch_unit_32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  jump;
  logic        branch;
  logic        alu_zero;
  logic [31:0] jr_target;
  logic        err_fetch;

  int total = 0;
  int bad   = 0;

  fetch_unit_32 #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump        (jump),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .jr_target   (jr_target),
    .err_fetch   (err_fetch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in FETCH; holds ack off for 'waits' cycles, then returns 'word'.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word, input int waits);
    imem_ack = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, addr);
      tick();
    end
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, word);
    check("hold_pc", instr_pc, addr);
    check("hold_req", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic retire(input logic [1:0] j, input logic br, input logic z, input logic [31:0] jr);
    jump        = j;
    branch      = br;
    alu_zero    = z;
    jr_target   = jr;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    jump        = JUMP_SEQ;
    branch      = 1'b0;
    alu_zero    = 1'b0;
    check("retire_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    jump        = JUMP_SEQ;
    branch      = 1'b0;
    alu_zero    = 1'b0;
    jr_target   = '0;
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_err", {31'd0, err_fetch}, 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req}, 32'd1);

    // Zero-wait memory, always ready: one instruction every two cycles.
    imem_ack    = 1'b1;
    imem_rdata  = 32'h0000_0020;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("seq_valid", {31'd0, instr_valid}, 32'd1);
      check("seq_instr_pc", instr_pc, 32'(4 * k));
      check("seq_req_low", {31'd0, imem_req}, 32'd0);
      tick();
      check("seq_req", {31'd0, imem_req}, 32'd1);
      check("seq_addr", imem_addr, 32'(4 * (k + 1)));
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;

    fetch_one(32'h0000_000C, 32'h0000_0000, 0);
    retire(JUMP_JR, 1'b0, 1'b0, 32'h0000_0100);
    // Taken beq with offset -2 words from 0x104.
    fetch_one(32'h0000_0100, 32'h1000_FFFE, 0);
    retire(JUMP_SEQ, 1'b1, 1'b1, 32'h0);
    // Branch not taken when alu_zero is low.
    fetch_one(32'h0000_00FC, 32'h1000_0010, 0);
    retire(JUMP_SEQ, 1'b1, 1'b0, 32'h0);
    // jump=01 beats a taken branch: 0x40 rather than 0x144.
    fetch_one(32'h0000_0100, 32'h1000_0010, 0);
    retire(JUMP_J, 1'b1, 1'b1, 32'h0);
    fetch_one(32'h0000_0040, 32'h0000_0000, 0);
    retire(JUMP_JR, 1'b0, 1'b0, 32'h1000_0000);
    fetch_one(32'h1000_0000, 32'h0800_0040, 2);
    retire(JUMP_J, 1'b0, 1'b0, 32'h0);

    // Three wait states, then a five-cycle stall with a stray ack.
    fetch_one(32'h1000_0100, 32'hDEAD_BEEF, 3);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (5) begin
      tick();
      check("stall_instr", instr, 32'hDEAD_BEEF);
      check("stall_pc", instr_pc, 32'h1000_0100);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    retire(JUMP_JR, 1'b0, 1'b0, 32'hFFFF_FFFC);

    // Sequential wrap past the top of the address space.
    fetch_one(32'hFFFF_FFFC, 32'h0000_0000, 1);
    retire(JUMP_SEQ, 1'b0, 1'b0, 32'h0);
    fetch_one(32'h0000_0000, 32'hCAFE_0001, 0);
    retire(JUMP_SEQ, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a pending request to 0x4.
    tick();
    check("pend_addr", imem_addr, 32'h0000_0004);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_instr_pc", instr_pc, 32'd0);
    check("mid_rst_addr", imem_addr, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0ABC;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_ack_pc", instr_pc, 32'd0);
    check("late_ack_instr", instr, 32'h0000_0ABC);

    // Misaligned jr target halts with pc unchanged.
    retire(JUMP_JR, 1'b0, 1'b0, 32'h0000_0202);
    check("mis_err", {31'd0, err_fetch}, 32'd1);
    check("mis_req", {31'd0, imem_req}, 32'd0);
    check("mis_pc_kept", imem_addr, 32'd0);
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    repeat (3) begin
      tick();
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_err", {31'd0, err_fetch}, 32'd1);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("clr_err", {31'd0, err_fetch}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("restart_req", {31'd0, imem_req}, 32'd1);

    // Invalid jump select halts as well.
    fetch_one(32'h0000_0000, 32'hFC00_0000, 0);
    retire(JUMP_INV, 1'b0, 1'b0, 32'h0);
    check("inv_err", {31'd0, err_fetch}, 32'd1);
    check("inv_req", {31'd0, imem_req}, 32'd0);
    check("inv_pc_kept", imem_addr, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
